// File: rtl/chacha_pkg.sv
// Shared ChaCha20 definitions: sigma constants, state layout, FSM encoding
// and the quarter-round function used by the half-round datapath.
package chacha_pkg;

    localparam logic [31:0] SIGMA0 = 32'h61707865;
    localparam logic [31:0] SIGMA1 = 32'h3320646e;
    localparam logic [31:0] SIGMA2 = 32'h79622d32;
    localparam logic [31:0] SIGMA3 = 32'h6b206574;

    localparam int DEFAULT_ROUNDS = 20;

    localparam int IDX_CONST   = 0;
    localparam int IDX_KEY     = 4;
    localparam int IDX_COUNTER = 12;
    localparam int IDX_NONCE   = 13;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_e;

    // Word i of the block lives at [i], so the flattened 512-bit view puts word 0 in the LSBs.
    typedef logic [15:0][31:0] chacha_state_t;
    typedef logic [3:0][31:0]  chacha_quad_t;

    function automatic chacha_quad_t quarter_round(input chacha_quad_t v);
        logic [31:0] a, b, c, d;
        a = v[0];
        b = v[1];
        c = v[2];
        d = v[3];
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

endpackage

// File: rtl/chacha_half_round.sv
// One ChaCha half-round: four parallel quarter-rounds over either the
// column quadruples or the diagonal quadruples of the 16-word state.
module chacha_half_round
    import chacha_pkg::*;
(
    input  chacha_state_t state_in,
    input  logic          diag,
    output chacha_state_t state_out
);

    chacha_quad_t [3:0] qr_in;
    chacha_quad_t [3:0] qr_out;

    for (genvar q = 0; q < 4; q++) begin : g_qr
        localparam int D1 = 4 + ((q + 1) % 4);
        localparam int D2 = 8 + ((q + 2) % 4);
        localparam int D3 = 12 + ((q + 3) % 4);

        assign qr_in[q] = diag ? {state_in[D3], state_in[D2], state_in[D1], state_in[q]}
                               : {state_in[q + 12], state_in[q + 8], state_in[q + 4], state_in[q]};
        assign qr_out[q] = quarter_round(qr_in[q]);
    end

    // Scatter each quarter-round result back to the words it was gathered from.
    always_comb begin
        state_out = state_in;
        for (int q = 0; q < 4; q++) begin
            state_out[q] = qr_out[q][0];
            if (diag) begin
                state_out[4 + ((q + 1) % 4)]  = qr_out[q][1];
                state_out[8 + ((q + 2) % 4)]  = qr_out[q][2];
                state_out[12 + ((q + 3) % 4)] = qr_out[q][3];
            end else begin
                state_out[q + 4]  = qr_out[q][1];
                state_out[q + 8]  = qr_out[q][2];
                state_out[q + 12] = qr_out[q][3];
            end
        end
    end

endmodule

// File: rtl/chacha_block_ctrl.sv
// ChaCha block-function sequencer: loads the initial state, runs one
// half-round per clock, adds the original state back and hands out the keystream.
module chacha_block_ctrl
    import chacha_pkg::*;
#(
    parameter int ROUNDS = DEFAULT_ROUNDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         busy,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream
);

    localparam int RND_W = $clog2(ROUNDS);
    localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_ctrl: ROUNDS must be 8, 12 or 20");
    end

    state_e           state_q, state_d;
    logic [RND_W-1:0] rnd_q, rnd_d;
    chacha_state_t    work_q, work_d;
    chacha_state_t    orig_q, orig_d;
    chacha_state_t    ks_q, ks_d;
    logic             out_valid_q, out_valid_d;
    chacha_state_t    init_state;
    chacha_state_t    hr_out;

    always_comb begin
        init_state = '0;
        init_state[IDX_CONST + 0] = SIGMA0;
        init_state[IDX_CONST + 1] = SIGMA1;
        init_state[IDX_CONST + 2] = SIGMA2;
        init_state[IDX_CONST + 3] = SIGMA3;
        for (int i = 0; i < 8; i++) begin
            init_state[IDX_KEY + i] = key[32*i +: 32];
        end
        init_state[IDX_COUNTER] = counter;
        for (int i = 0; i < 3; i++) begin
            init_state[IDX_NONCE + i] = nonce[32*i +: 32];
        end
    end

    // Even rounds are column rounds, odd rounds are diagonal rounds.
    chacha_half_round u_half_round (
        .state_in  (work_q),
        .diag      (rnd_q[0]),
        .state_out (hr_out)
    );

    always_comb begin
        state_d     = state_q;
        rnd_d       = rnd_q;
        work_d      = work_q;
        orig_d      = orig_q;
        ks_d        = ks_q;
        out_valid_d = out_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = init_state;
                    orig_d  = init_state;
                    rnd_d   = '0;
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: begin
                work_d = hr_out;
                // Exiting at the last round keeps the counter from ever wrapping.
                if (rnd_q == LAST_RND) begin
                    for (int i = 0; i < 16; i++) begin
                        ks_d[i] = hr_out[i] + orig_q[i];
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            work_q      <= '0;
            orig_q      <= '0;
            ks_q        <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            work_q      <= work_d;
            orig_q      <= orig_d;
            ks_q        <= ks_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_ctrl.sv
// Self-checking bench for chacha_block_ctrl: table-driven vectors against a
// software ChaCha model, plus backpressure, ignored-start, reset and ChaCha8 sequences.
module tb_chacha_block_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;

    logic         start, in_ready, busy, out_valid, out_ready;
    logic [255:0] key;
    logic [31:0]  counter;
    logic [95:0]  nonce;
    logic [511:0] keystream;

    logic         start_8, in_ready_8, busy_8, out_valid_8, out_ready_8;
    logic [255:0] key_8;
    logic [31:0]  counter_8;
    logic [95:0]  nonce_8;
    logic [511:0] keystream_8;

    chacha_block_ctrl #(.ROUNDS(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_ready  (in_ready),
        .key       (key),
        .counter   (counter),
        .nonce     (nonce),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .keystream (keystream)
    );

    chacha_block_ctrl #(.ROUNDS(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_8),
        .in_ready  (in_ready_8),
        .key       (key_8),
        .counter   (counter_8),
        .nonce     (nonce_8),
        .busy      (busy_8),
        .out_valid (out_valid_8),
        .out_ready (out_ready_8),
        .keystream (keystream_8)
    );

    localparam logic [255:0] RFC_KEY   = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [31:0]  RFC_CTR   = 32'h00000001;
    localparam logic [95:0]  RFC_NONCE = 96'h00000000_4a000000_09000000;

    typedef struct {
        logic [255:0] key;
        logic [31:0]  counter;
        logic [95:0]  nonce;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w15;
    } vec_t;

    vec_t vecs [4];

    int n_checks = 0;
    int n_fail   = 0;

    logic [511:0] exp20_q [$];
    logic [511:0] exp8_q  [$];

    int diag_tbl [4][4] = '{'{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};

    // Software reference model of the ChaCha block function.
    function automatic logic [127:0] qr_model(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    function automatic logic [511:0] chacha_model(input logic [255:0] k, input logic [31:0] ctr,
                                                  input logic [95:0] n, input int rounds);
        logic [31:0]  s [16];
        logic [31:0]  x [16];
        logic [127:0] t;
        logic [511:0] res;
        int           idx [4];
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13+i] = n[32*i +: 32];
        x = s;
        for (int r = 0; r < rounds; r++) begin
            for (int q = 0; q < 4; q++) begin
                for (int j = 0; j < 4; j++) idx[j] = (r % 2 == 0) ? (q + 4*j) : diag_tbl[q][j];
                t = qr_model(x[idx[0]], x[idx[1]], x[idx[2]], x[idx[3]]);
                x[idx[0]] = t[31:0];
                x[idx[1]] = t[63:32];
                x[idx[2]] = t[95:64];
                x[idx[3]] = t[127:96];
            end
        end
        for (int i = 0; i < 16; i++) res[32*i +: 32] = x[i] + s[i];
        return res;
    endfunction

    task automatic check_value(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one request, push the model's answer, and confirm acceptance at the next edge.
    task automatic apply_stimulus(input bit sel, input logic [255:0] k, input logic [31:0] c,
                                  input logic [95:0] n, input bit scramble);
        @(negedge clk);
        if (sel) begin
            key_8 = k; counter_8 = c; nonce_8 = n; start_8 = 1'b1;
            exp8_q.push_back(chacha_model(k, c, n, 8));
        end else begin
            key = k; counter = c; nonce = n; start = 1'b1;
            exp20_q.push_back(chacha_model(k, c, n, 20));
        end
        @(posedge clk);
        #1;
        if (sel) begin
            start_8 = 1'b0;
            check_value("accept_8", {in_ready_8, busy_8}, 2'b01);
        end else begin
            start = 1'b0;
            check_value("accept", {in_ready, busy}, 2'b01);
            if (scramble) begin
                key = ~k; counter = c + 32'd77; nonce = ~n;
            end
        end
    endtask

    // Counts edges since acceptance (inclusive) until out_valid, bounded.
    task automatic wait_valid(input bit sel, output int edges);
        edges = 1;
        while (!(sel ? out_valid_8 : out_valid) && edges < 64) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_output(input bit sel, input string name);
        logic [511:0] exp;
        if (sel) begin
            if (exp8_q.size() == 0) begin
                check_value({name, "_sb_empty"}, 1'b1, 1'b0);
            end else begin
                exp = exp8_q.pop_front();
                check_value(name, keystream_8, exp);
            end
        end else begin
            if (exp20_q.size() == 0) begin
                check_value({name, "_sb_empty"}, 1'b1, 1'b0);
            end else begin
                exp = exp20_q.pop_front();
                check_value(name, keystream, exp);
            end
        end
    endtask

    task automatic handshake(input bit sel, input string name);
        if (sel) out_ready_8 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1;
        if (sel) begin
            out_ready_8 = 1'b0;
            check_value(name, {out_valid_8, in_ready_8, busy_8}, 3'b010);
        end else begin
            out_ready = 1'b0;
            check_value(name, {out_valid, in_ready, busy}, 3'b010);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           edges;
        logic [511:0] ks_hold;
        logic         spurious;

        vecs[0] = '{RFC_KEY, RFC_CTR, RFC_NONCE, 32'he4e7f110, 32'h4e3c50a2};
        vecs[1] = '{256'h0, 32'h0, 96'h0, 32'hade0b876, 32'h0};
        vecs[2] = '{{8{32'hdeadbeef}}, 32'hffffffff, 96'h0123456789abcdef01234567, 32'h0, 32'h0};
        vecs[3] = '{{256{1'b1}}, 32'h80000000, {96{1'b1}}, 32'h0, 32'h0};
        for (int v = 1; v < 4; v++) begin
            ks_hold = chacha_model(vecs[v].key, vecs[v].counter, vecs[v].nonce, 20);
            if (v != 1) vecs[v].exp_w0 = ks_hold[31:0];
            vecs[v].exp_w15 = ks_hold[511:480];
        end

        rst_n = 1'b0;
        start = 1'b0; out_ready = 1'b0; key = '0; counter = '0; nonce = '0;
        start_8 = 1'b0; out_ready_8 = 1'b0; key_8 = '0; counter_8 = '0; nonce_8 = '0;
        #1;
        check_value("reset_ctrl", {in_ready, busy, out_valid}, 3'b100);
        check_value("reset_keystream", keystream, '0);
        check_value("reset_ctrl_8", {in_ready_8, busy_8, out_valid_8}, 3'b100);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            apply_stimulus(1'b0, vecs[v].key, vecs[v].counter, vecs[v].nonce, 1'b0);
            wait_valid(1'b0, edges);
            check_value($sformatf("vec%0d_latency", v), edges, 21);
            check_value($sformatf("vec%0d_word0", v), keystream[31:0], vecs[v].exp_w0);
            check_value($sformatf("vec%0d_word15", v), keystream[511:480], vecs[v].exp_w15);
            check_output(1'b0, $sformatf("vec%0d_keystream", v));
            handshake(1'b0, $sformatf("vec%0d_release", v));
        end

        apply_stimulus(1'b0, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b0);
        wait_valid(1'b0, edges);
        check_value("bp_latency", edges, 21);
        ks_hold = keystream;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_value($sformatf("bp_hold_ctrl%0d", i), {out_valid, in_ready, busy}, 3'b101);
            check_value($sformatf("bp_hold_ks%0d", i), keystream, ks_hold);
        end
        check_output(1'b0, "bp_keystream");
        handshake(1'b0, "bp_release");

        apply_stimulus(1'b0, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b0);
        fork
            begin
                repeat (4) @(negedge clk);
                key = {256{1'b1}}; counter = 32'h5; start = 1'b1;
                repeat (3) @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_valid(1'b0, edges);
        check_value("busy_start_latency", edges, 21);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_value("done_start_ignored", {out_valid, in_ready, busy}, 3'b101);
        start = 1'b0;
        check_output(1'b0, "busy_start_keystream");
        handshake(1'b0, "busy_start_release");

        apply_stimulus(1'b0, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b1);
        wait_valid(1'b0, edges);
        check_value("scramble_latency", edges, 21);
        check_value("scramble_word0", keystream[31:0], 32'he4e7f110);
        check_output(1'b0, "scramble_keystream");
        handshake(1'b0, "scramble_release");

        apply_stimulus(1'b0, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        check_value("pre_reset_busy", {out_valid, busy}, 2'b01);
        rst_n = 1'b0;
        #1;
        check_value("midreset_ctrl", {in_ready, busy, out_valid}, 3'b100);
        check_value("midreset_keystream", keystream, '0);
        void'(exp20_q.pop_back());
        spurious = 1'b0;
        repeat (25) begin
            @(posedge clk);
            #1;
            spurious = spurious | out_valid;
        end
        check_value("midreset_no_valid", spurious, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b0);
        wait_valid(1'b0, edges);
        check_value("post_reset_latency", edges, 21);
        check_value("post_reset_word15", keystream[511:480], 32'h4e3c50a2);
        check_output(1'b0, "post_reset_keystream");
        handshake(1'b0, "post_reset_release");

        apply_stimulus(1'b1, 256'h0, 32'h0, 96'h0, 1'b0);
        wait_valid(1'b1, edges);
        check_value("chacha8_zero_latency", edges, 9);
        check_output(1'b1, "chacha8_zero_keystream");
        handshake(1'b1, "chacha8_zero_release");

        apply_stimulus(1'b1, RFC_KEY, RFC_CTR, RFC_NONCE, 1'b0);
        wait_valid(1'b1, edges);
        check_value("chacha8_rfc_latency", edges, 9);
        check_output(1'b1, "chacha8_rfc_keystream");
        handshake(1'b1, "chacha8_rfc_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chacha_block_ctrl.md
Name: chacha_block_ctrl

Overview:
Sequences the ChaCha20 quarter-round datapath (four QR instances) over the full block function defined in RFC 8439. It loads the 16-word state from constants, key, counter and nonce, then runs one half-round (column or diagonal) per clock. It adds the original state back in and presents a 512-bit keystream block through a valid/ready handshake. It sits between the key/nonce configuration logic and the XOR/stream engine.

Parameters:
ROUNDS, 20, number of half-rounds (column and diagonal counted separately); must be even, legal values 8/12/20; any other value is a build-time error.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request a block; accepted only when in_ready=1
in_ready  output  1  high in IDLE only
key  input  256  key; key[32*i+:32] is state word 4+i
counter  input  32  block counter, state word 12
nonce  input  96  nonce; nonce[32*i+:32] is state word 13+i
busy  output  1  high in ROUND or DONE
out_valid  output  1  keystream valid; held until out_ready
out_ready  input  1  consumer accepts keystream
keystream  output  512  keystream[32*i+:32] = final word i

Behaviour:
- Reset (async assert, sync deassert externally): state=IDLE, round counter=0, working and original state registers=0, keystream=0, out_valid=0, busy=0, in_ready=1.
- Initial state: words 0..3 = 0x61707865, 0x3320646e, 0x79622d32, 0x6b206574. Words 4..11 = key, 12 = counter, 13..15 = nonce.
- IDLE: if start, load the working and original state from the inputs; rnd=0; go to ROUND. key/counter/nonce are sampled only on this edge; later changes have no effect.
- ROUND: each clock applies 4 QRs to the working state.
  - rnd even (column): (0,4,8,12) (1,5,9,13) (2,6,10,14) (3,7,11,15).
  - rnd odd (diagonal): (0,5,10,15) (1,6,11,12) (2,7,8,13) (3,4,9,14).
  - rnd increments each clock.
  - On the clock where rnd==ROUNDS-1: keystream[i] <= roundresult[i] + original[i] (mod 2^32 per word); out_valid<=1; go to DONE.
- Latency: start accepted at edge N; out_valid rises after edge N+ROUNDS (21 edges total for ROUNDS=20).
- DONE: keystream and out_valid held stable. On out_valid&&out_ready, out_valid<=0 and go to IDLE. start is ignored in DONE.
- start while busy: ignored, no effect on the sequence in progress.
- Round counter: width clog2(ROUNDS); never wraps, because exit happens at ROUNDS-1.
- Reset mid-operation: immediate return to reset values; the partial block is discarded and no out_valid pulse is produced.
- keystream may be 0 or stale when out_valid=0; consumers must not sample it then.

Decomposition:
- chacha_pkg: the four sigma constants, default ROUNDS, state-word index constants, FSM state enum (IDLE/ROUND/DONE), 16x32 state array type.
- One sub-module, chacha_half_round: combinational. Instantiates 4 QR. Takes the 16-word state plus a diag select and returns the 16-word state, routing column or diagonal quadruples. chacha_block_ctrl holds the FSM, registers and final add.

Test Plan:
- RFC 8439 §2.3.2 vector: key bytes 00..1f (word4=0x03020100), counter=1, nonce words 0x09000000/0x4a000000/0x00000000, start one cycle → out_valid after exactly 21 edges; word0=0xe4e7f110, word15=0x4e3c50a2.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → keystream and out_valid stable, in_ready=0. Pulse out_ready → out_valid=0 and in_ready=1 next cycle.
- start asserted during ROUND with different key → ignored; output matches the first request's vector.
- Inputs changed one cycle after acceptance → output unchanged (RFC vector still produced).
- Assert rst_n=0 at round 7 → outputs zero immediately. Release and issue the RFC request → correct vector, with no spurious out_valid before it.
- ROUNDS=8 build with an all-zero key/nonce/counter → out_valid after 9 edges; result matches the software ChaCha8 model.
